// File: rtl/alt_vipitc130_timing_pkg.sv
// Shared types for the mode timing controller.
//   state_t  : raster sequencer states (idle, one-cycle start, running)
//   region_t : where a count sits within a line/column (active, porches, sync)
//   SUM_EXTRA_BITS : headroom added to a field width when four fields are summed
package alt_vipitc130_timing_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        ACTIVE,
        FP,
        SYNC,
        BP
    } region_t;

    // Four fields of width W sum into at most W+2 bits.
    localparam int SUM_EXTRA_BITS = 2;

endpackage

// File: rtl/alt_vipitc130_axis_counter.sv
// One raster axis (horizontal pixels or vertical lines).
// Wrapping counter with restart and advance, plus region decode.
//   clk, rst        : pixel clock, asynchronous active-high reset
//   advance         : step the count this cycle (wraps to 0 after total-1)
//   restart         : force the count to 0 (overrides advance)
//   *_len           : mode fields that will be in force next cycle
//   count           : current position (registered)
//   last            : current position is total-1 (registered)
//   in_active       : next position is in the active region
//   in_sync         : next position is in the sync region
//   last_next       : next position is total-1
//   zero_next       : next position is 0
//
// The *_next / in_* outputs describe the position being loaded at the
// coming edge. This lets the top register its outputs so they line up
// with count.
module alt_vipitc130_axis_counter
    import alt_vipitc130_timing_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             restart,
    input  logic [WIDTH-1:0] active_len,
    input  logic [WIDTH-1:0] fp_len,
    input  logic [WIDTH-1:0] sync_len,
    input  logic [WIDTH-1:0] bp_len,
    output logic [WIDTH-1:0] count,
    output logic             last,
    output logic             in_active,
    output logic             in_sync,
    output logic             last_next,
    output logic             zero_next
);

    localparam int SW = WIDTH + SUM_EXTRA_BITS;

    logic [WIDTH-1:0] count_next;
    logic [SW-1:0]    sync_start;
    logic [SW-1:0]    sync_end;
    logic [SW-1:0]    total;
    logic [SW-1:0]    count_ext;
    region_t          region;

    assign sync_start = SW'(active_len) + SW'(fp_len);
    assign sync_end   = sync_start + SW'(sync_len);
    assign total      = sync_end + SW'(bp_len);

    // The wrap uses the registered "last" flag, so the count wraps against
    // the total that was in force when the current position was loaded.
    always_comb begin
        count_next = count;
        if (restart) begin
            count_next = '0;
        end else if (advance) begin
            count_next = last ? '0 : count + WIDTH'(1);
        end
    end

    // Region decode of the upcoming position against the upcoming mode.
    always_comb begin
        count_ext = SW'(count_next);
        region    = BP;
        if (count_ext < SW'(active_len)) begin
            region = ACTIVE;
        end else if (count_ext < sync_start) begin
            region = FP;
        end else if (count_ext < sync_end) begin
            region = SYNC;
        end
        in_active = (region == ACTIVE);
        in_sync   = (region == SYNC);
        last_next = (count_ext == total - SW'(1));
        zero_next = (count_next == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            last  <= 1'b0;
        end else begin
            count <= count_next;
            last  <= last_next;
        end
    end

endmodule

// File: rtl/alt_vipitc130_mode_timing_ctrl.sv
// Video mode timing controller.
// A double-buffered mode register drives two raster counters that produce
// sync, blank and data-enable signals plus frame markers.
//   clk, rst            : pixel clock, asynchronous active-high reset
//   enable              : run the raster (low = idle)
//   cfg_*               : requested mode fields and sync polarities
//   cfg_valid/cfg_ready : mode load handshake (ready while nothing pending)
//   cfg_error           : one-cycle pulse when a request is rejected
//   mode_pending        : accepted mode waiting for a frame boundary
//   h_count, v_count    : current pixel and line
//   hsync, vsync, de    : timing outputs (registered, aligned with counts)
//   sof, eof            : first and last pixel of a frame
module alt_vipitc130_mode_timing_ctrl
    import alt_vipitc130_timing_pkg::*;
#(
    parameter int H_WIDTH        = 12,
    parameter int V_WIDTH        = 12,
    parameter int RESET_H_ACTIVE = 1280,
    parameter int RESET_H_FP     = 110,
    parameter int RESET_H_SYNC   = 40,
    parameter int RESET_H_BP     = 220,
    parameter int RESET_V_ACTIVE = 720,
    parameter int RESET_V_FP     = 5,
    parameter int RESET_V_SYNC   = 5,
    parameter int RESET_V_BP     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [H_WIDTH-1:0] cfg_h_active,
    input  logic [H_WIDTH-1:0] cfg_h_fp,
    input  logic [H_WIDTH-1:0] cfg_h_sync,
    input  logic [H_WIDTH-1:0] cfg_h_bp,
    input  logic [V_WIDTH-1:0] cfg_v_active,
    input  logic [V_WIDTH-1:0] cfg_v_fp,
    input  logic [V_WIDTH-1:0] cfg_v_sync,
    input  logic [V_WIDTH-1:0] cfg_v_bp,
    input  logic               cfg_hsync_pol,
    input  logic               cfg_vsync_pol,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic               cfg_error,
    output logic               mode_pending,
    output logic [H_WIDTH-1:0] h_count,
    output logic [V_WIDTH-1:0] v_count,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               sof,
    output logic               eof
);

    localparam int HSW = H_WIDTH + SUM_EXTRA_BITS;
    localparam int VSW = V_WIDTH + SUM_EXTRA_BITS;

    state_t state, state_next;

    // Active (in-use) and shadow (pending) mode registers.
    logic [H_WIDTH-1:0] act_h_active, act_h_fp, act_h_sync, act_h_bp;
    logic [V_WIDTH-1:0] act_v_active, act_v_fp, act_v_sync, act_v_bp;
    logic               act_hsync_pol, act_vsync_pol;
    logic [H_WIDTH-1:0] shd_h_active, shd_h_fp, shd_h_sync, shd_h_bp;
    logic [V_WIDTH-1:0] shd_v_active, shd_v_fp, shd_v_sync, shd_v_bp;
    logic               shd_hsync_pol, shd_vsync_pol;

    // Mode that will be in force in the next cycle (shadow when committing).
    logic [H_WIDTH-1:0] nx_h_active, nx_h_fp, nx_h_sync, nx_h_bp;
    logic [V_WIDTH-1:0] nx_v_active, nx_v_fp, nx_v_sync, nx_v_bp;
    logic               nx_hsync_pol, nx_vsync_pol;

    logic [HSW-1:0] req_h_total;
    logic [VSW-1:0] req_v_total;
    logic handshake, req_bad, commit, eof_now, restart, run_next;
    logic h_last, h_in_active, h_in_sync, h_last_next, h_zero_next;
    logic v_last, v_in_active, v_in_sync, v_last_next, v_zero_next;

    assign cfg_ready   = !mode_pending;
    assign handshake   = cfg_valid && cfg_ready;
    assign req_h_total = HSW'(cfg_h_active) + HSW'(cfg_h_fp) + HSW'(cfg_h_sync) + HSW'(cfg_h_bp);
    assign req_v_total = VSW'(cfg_v_active) + VSW'(cfg_v_fp) + VSW'(cfg_v_sync) + VSW'(cfg_v_bp);
    assign req_bad     = (cfg_h_active == '0) || (cfg_v_active == '0) ||
                         (cfg_h_sync == '0)   || (cfg_v_sync == '0)   ||
                         (req_h_total > HSW'({H_WIDTH{1'b1}})) ||
                         (req_v_total > VSW'({V_WIDTH{1'b1}}));

    // A pending mode commits straight away when idle, otherwise only on the
    // last pixel of a frame so the raster never tears.
    assign eof_now = (state != IDLE) && h_last && v_last;
    assign commit  = mode_pending && ((state == IDLE) || eof_now);

    assign nx_h_active  = commit ? shd_h_active  : act_h_active;
    assign nx_h_fp      = commit ? shd_h_fp      : act_h_fp;
    assign nx_h_sync    = commit ? shd_h_sync    : act_h_sync;
    assign nx_h_bp      = commit ? shd_h_bp      : act_h_bp;
    assign nx_v_active  = commit ? shd_v_active  : act_v_active;
    assign nx_v_fp      = commit ? shd_v_fp      : act_v_fp;
    assign nx_v_sync    = commit ? shd_v_sync    : act_v_sync;
    assign nx_v_bp      = commit ? shd_v_bp      : act_v_bp;
    assign nx_hsync_pol = commit ? shd_hsync_pol : act_hsync_pol;
    assign nx_vsync_pol = commit ? shd_vsync_pol : act_vsync_pol;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = START;
            START:   state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counters sit at 0 in IDLE and START; START itself is pixel (0,0).
    assign restart  = (state_next == IDLE) || (state_next == START);
    assign run_next = (state_next != IDLE);

    alt_vipitc130_axis_counter #(.WIDTH(H_WIDTH)) u_h_counter (
        .clk        (clk),
        .rst        (rst),
        .advance    (1'b1),
        .restart    (restart),
        .active_len (nx_h_active),
        .fp_len     (nx_h_fp),
        .sync_len   (nx_h_sync),
        .bp_len     (nx_h_bp),
        .count      (h_count),
        .last       (h_last),
        .in_active  (h_in_active),
        .in_sync    (h_in_sync),
        .last_next  (h_last_next),
        .zero_next  (h_zero_next)
    );

    alt_vipitc130_axis_counter #(.WIDTH(V_WIDTH)) u_v_counter (
        .clk        (clk),
        .rst        (rst),
        .advance    (h_last),
        .restart    (restart),
        .active_len (nx_v_active),
        .fp_len     (nx_v_fp),
        .sync_len   (nx_v_sync),
        .bp_len     (nx_v_bp),
        .count      (v_count),
        .last       (v_last),
        .in_active  (v_in_active),
        .in_sync    (v_in_sync),
        .last_next  (v_last_next),
        .zero_next  (v_zero_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Mode register bank: commit and accept never coincide because accept
    // needs mode_pending low and commit needs it high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_h_active  <= H_WIDTH'(RESET_H_ACTIVE);
            act_h_fp      <= H_WIDTH'(RESET_H_FP);
            act_h_sync    <= H_WIDTH'(RESET_H_SYNC);
            act_h_bp      <= H_WIDTH'(RESET_H_BP);
            act_v_active  <= V_WIDTH'(RESET_V_ACTIVE);
            act_v_fp      <= V_WIDTH'(RESET_V_FP);
            act_v_sync    <= V_WIDTH'(RESET_V_SYNC);
            act_v_bp      <= V_WIDTH'(RESET_V_BP);
            act_hsync_pol <= 1'b1;
            act_vsync_pol <= 1'b1;
            shd_h_active  <= '0;
            shd_h_fp      <= '0;
            shd_h_sync    <= '0;
            shd_h_bp      <= '0;
            shd_v_active  <= '0;
            shd_v_fp      <= '0;
            shd_v_sync    <= '0;
            shd_v_bp      <= '0;
            shd_hsync_pol <= 1'b0;
            shd_vsync_pol <= 1'b0;
            mode_pending  <= 1'b0;
            cfg_error     <= 1'b0;
        end else begin
            cfg_error <= handshake && req_bad;
            if (commit) begin
                act_h_active  <= shd_h_active;
                act_h_fp      <= shd_h_fp;
                act_h_sync    <= shd_h_sync;
                act_h_bp      <= shd_h_bp;
                act_v_active  <= shd_v_active;
                act_v_fp      <= shd_v_fp;
                act_v_sync    <= shd_v_sync;
                act_v_bp      <= shd_v_bp;
                act_hsync_pol <= shd_hsync_pol;
                act_vsync_pol <= shd_vsync_pol;
                mode_pending  <= 1'b0;
            end else if (handshake && !req_bad) begin
                shd_h_active  <= cfg_h_active;
                shd_h_fp      <= cfg_h_fp;
                shd_h_sync    <= cfg_h_sync;
                shd_h_bp      <= cfg_h_bp;
                shd_v_active  <= cfg_v_active;
                shd_v_fp      <= cfg_v_fp;
                shd_v_sync    <= cfg_v_sync;
                shd_v_bp      <= cfg_v_bp;
                shd_hsync_pol <= cfg_hsync_pol;
                shd_vsync_pol <= cfg_vsync_pol;
                mode_pending  <= 1'b1;
            end
        end
    end

    // Timing outputs are decoded from the upcoming counts and mode so that,
    // once registered, they line up with h_count/v_count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de    <= 1'b0;
            hsync <= 1'b0;
            vsync <= 1'b0;
            sof   <= 1'b0;
            eof   <= 1'b0;
        end else begin
            de    <= run_next && h_in_active && v_in_active;
            hsync <= (run_next && h_in_sync) ? nx_hsync_pol : !nx_hsync_pol;
            vsync <= (run_next && v_in_sync) ? nx_vsync_pol : !nx_vsync_pol;
            sof   <= (state_next == START) ||
                     ((state_next == RUN) && h_zero_next && v_zero_next);
            eof   <= run_next && h_last_next && v_last_next;
        end
    end

endmodule

// File: doc/alt_vipitc130_mode_timing_ctrl.md
Name: alt_vipitc130_mode_timing_ctrl

Overview:
- Sequences a pair of raster counters (horizontal pixel, vertical line) into a full video timing frame. It generates the sync, blank and data-enable signals plus frame markers.
- Owns a double-buffered mode register set with a valid/ready configuration handshake.
- New modes are validated on arrival and committed only at a frame boundary, so the output raster never tears.
- Sits between the control-slave register bank and the clocked-video output pixel path.

Parameters:
- H_WIDTH, 12, width of horizontal count and horizontal config fields
- V_WIDTH, 12, width of vertical count and vertical config fields
- RESET_H_ACTIVE, 1280, reset-time horizontal active pixels (same pattern for RESET_H_FP 110, RESET_H_SYNC 40, RESET_H_BP 220)
- RESET_V_ACTIVE, 720, reset-time vertical active lines (same pattern for RESET_V_FP 5, RESET_V_SYNC 5, RESET_V_BP 20)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  run raster; low = idle
- cfg_h_active / cfg_h_fp / cfg_h_sync / cfg_h_bp  in  H_WIDTH each  requested horizontal mode
- cfg_v_active / cfg_v_fp / cfg_v_sync / cfg_v_bp  in  V_WIDTH each  requested vertical mode
- cfg_hsync_pol, cfg_vsync_pol  in  1 each  sync active level (1 = active-high)
- cfg_valid  in  1  request mode load
- cfg_ready  out  1  shadow register free
- cfg_error  out  1  one-cycle pulse: request rejected
- mode_pending  out  1  accepted mode awaiting commit
- h_count  out  H_WIDTH  current pixel
- v_count  out  V_WIDTH  current line
- hsync, vsync, de  out  1 each  timing outputs
- sof, eof  out  1 each  first pixel / last pixel of frame

Behaviour:
- Line order: active, front porch, sync, back porch.
  - h_total = sum of the four h fields; v_total likewise.
  - Sums are computed H_WIDTH+2 (V_WIDTH+2) bits wide.
- Validation on a handshake (cfg_valid && cfg_ready). The request is rejected (cfg_error = 1 for 1 cycle, nothing stored) if any of the following holds:
  - any active field is 0
  - any sync field is 0
  - h_total > 2^H_WIDTH - 1
  - v_total > 2^V_WIDTH - 1
  - Porch fields may be 0.
- On accept: fields are stored in the shadow register and mode_pending is set. cfg_ready = !mode_pending.
- FSM states:
  - IDLE: counters held at 0; de = 0; sof = eof = 0; syncs at inactive level. A pending mode commits in the next cycle.
    - enable = 1 → START.
  - START: one cycle; counters = 0; sof = 1.
    - → RUN.
  - RUN: h_count increments every cycle and wraps to 0 after h_total-1. v_count increments on the h wrap and wraps to 0 after v_total-1.
    - At h = h_total-1 and v = v_total-1: eof = 1. If mode_pending, the shadow copies to the active register at that edge and pending clears. The next cycle runs the new mode from 0,0 with sof = 1.
    - enable = 0 → IDLE at the next edge (frame aborted, no eof). A pending mode commits in IDLE.
- Outputs are registered and aligned with h_count/v_count in the same cycle.
  - de = (h < h_active) && (v < v_active).
  - hsync active when h_active+h_fp <= h < h_active+h_fp+h_sync.
  - vsync is decoded the same way on v, independent of h.
  - Outputs use the polarities in the active register.
- sof is asserted at v = 0, h = 0 in RUN.
- Simultaneous events:
  - A handshake in the commit cycle: the new request cannot be accepted, because cfg_ready = 0 while pending.
  - A handshake in the cycle after commit is accepted normally.
- Reset:
  - The active register loads the RESET_* values with positive polarities.
  - Shadow cleared; mode_pending = 0; cfg_ready = 1; cfg_error = 0.
  - State = IDLE; counters = 0.
  - hsync = vsync = 0; de = sof = eof = 0.
  - Reset asserted mid-frame forces this state asynchronously.

Decomposition:
- Package alt_vipitc130_timing_pkg holds:
  - state enum (IDLE, START, RUN)
  - region enum (ACTIVE, FP, SYNC, BP)
  - localparams for sum widths
- One sub-module, alt_vipitc130_axis_counter, instantiated twice. Each instance provides:
  - the wrapping counter, with enable, restart, and total-1 as the max
  - region-boundary decode, outputting in_active, in_sync and last

Test Plan:
- Mode h 4/1/2/1 (total 8), v 3/1/1/1 (total 6), polarities 1,1. Load in IDLE, then enable → frame period 48 cycles.
  - sof on cycle 0, eof on cycle 47.
  - de high for h 0-3 on lines 0-2.
  - hsync high at h 5-6; vsync high on line 4.
- Accept a new mode mid-frame → cfg_ready stays 0 until the eof edge; the first sof afterwards uses the new totals; mode_pending clears at the commit.
- cfg_h_active = 0, or h fields summing to 4096 at H_WIDTH 12 → cfg_error single pulse; mode_pending stays 0; raster unchanged.
- Drop enable at h = 3, v = 1 → next cycle IDLE with counters 0, de = 0, no eof. Re-enable → START, with sof on the first pixel.
- Polarity 0,0 with the small mode → hsync low only at h 5-6; syncs high in IDLE.
- Assert rst mid-frame → all outputs at reset values without waiting for a clock edge. After release and enable, the raster runs with the RESET_* 1280x720 totals (1650 x 750).
